// File: rtl/uart_tx_fifo_if.sv
// Enqueue-side bus of the UART transmitter: the word, its strobe, and the
// FIFO status returned to the producer.
interface uart_tx_fifo_if #(
    parameter int dataBits  = 8,
    parameter int fifoDepth = 16
);
    logic [dataBits-1:0]        data;
    logic                       send_trigger;
    logic                       ready;
    logic [$clog2(fifoDepth):0] fifo_count;

    modport master (
        output data,
        output send_trigger,
        input  ready,
        input  fifo_count
    );

    modport slave (
        input  data,
        input  send_trigger,
        output ready,
        output fifo_count
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a TX FIFO.
// Words pushed over the bus are queued and then framed as
// start / data (LSB first) / optional parity / stop bits.
// Frames go out back to back while the FIFO holds words.
module uart_tx_fifo #(
    parameter int clkFreq    = 100000000,
    parameter int baudRate   = 115200,
    parameter int dataBits   = 8,
    parameter int parityMode = 0,
    parameter int stopBits   = 1,
    parameter int fifoDepth  = 16
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fifo_if.slave bus,
    output logic          signal,
    output logic          busy
);
    localparam int CLK_PER_BIT = clkFreq / baudRate;
    localparam int CNT_W       = $clog2(CLK_PER_BIT + 1);
    localparam int PTR_W       = $clog2(fifoDepth);
    localparam int COUNT_W     = PTR_W + 1;
    localparam int BIT_W       = 4;
    localparam logic ODD_PAR   = (parityMode == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t r_state;
    state_t w_state_n;

    // FIFO storage and bookkeeping
    logic [dataBits-1:0] r_mem [fifoDepth];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [COUNT_W-1:0]  r_count;

    // Frame datapath
    logic [CNT_W-1:0]    r_clk_cnt;
    logic [BIT_W-1:0]    r_bit_idx;
    logic [dataBits-1:0] r_shift;
    logic                r_par;
    logic                r_signal;

    logic                w_push;
    logic                w_pop;
    logic                w_empty;
    logic                w_ready;
    logic                w_tick;
    logic                w_last_data;
    logic                w_last_stop;
    logic [dataBits-1:0] w_head;
    logic                w_par_head;
    logic [dataBits-1:0] w_shift_n;
    logic                w_line_n;

    assign w_empty     = (r_count == '0);
    assign w_ready     = (r_count < COUNT_W'(fifoDepth));
    assign w_push      = bus.send_trigger && w_ready;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_par_head  = (^w_head) ^ ODD_PAR;
    assign w_tick      = (r_clk_cnt == CNT_W'(CLK_PER_BIT - 1));
    assign w_last_data = (r_bit_idx == BIT_W'(dataBits - 1));
    assign w_last_stop = (r_bit_idx == BIT_W'(stopBits - 1));

    assign bus.ready      = w_ready;
    assign bus.fifo_count = r_count;
    assign signal         = r_signal;
    assign busy           = (r_state != IDLE);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next state, pop decision, next shift contents and next line level
    always_comb begin
        w_state_n = r_state;
        w_pop     = 1'b0;
        w_shift_n = r_shift;
        w_line_n  = 1'b1;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_state_n = START;
                    w_pop     = 1'b1;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_n = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shift_n = r_shift >> 1;
                    if (w_last_data) begin
                        w_state_n = (parityMode != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_state_n = STOP;
                end
            end
            STOP: begin
                if (w_tick && w_last_stop) begin
                    if (!w_empty) begin
                        w_state_n = START;
                        w_pop     = 1'b1;
                    end else begin
                        w_state_n = IDLE;
                    end
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase

        if (w_pop) begin
            w_shift_n = w_head;
        end

        // The line level is chosen for the state being entered, so the
        // registered output changes on the same edge as the state.
        case (w_state_n)
            START:   w_line_n = 1'b0;
            DATA:    w_line_n = w_shift_n[0];
            PARITY:  w_line_n = r_par;
            default: w_line_n = 1'b1;
        endcase
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.data;
        end
    end

    // Bit timing, shift register, parity latch and registered line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_signal  <= 1'b1;
        end else begin
            if (r_state == IDLE || w_tick || w_pop) begin
                r_clk_cnt <= '0;
            end else begin
                r_clk_cnt <= r_clk_cnt + 1'b1;
            end

            if (w_state_n != r_state) begin
                r_bit_idx <= '0;
            end else if (w_tick) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end

            r_shift  <= w_shift_n;
            r_signal <= w_line_n;
            if (w_pop) begin
                r_par <= w_par_head;
            end
        end
    end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter clkFreq, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter baudRate, default 115200, line rate in bits/s.
REQ-003 SHALL have parameter dataBits, default 8, payload bits per frame, legal range 5..9.
REQ-004 SHALL have parameter parityMode, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 SHALL have parameter stopBits, default 1, stop bits per frame, legal values 1 or 2.
REQ-006 SHALL have parameter fifoDepth, default 16, TX FIFO entries, power of two and at least 2.
REQ-007 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port data  input  dataBits  word to enqueue.
REQ-010 SHALL have port send_trigger  input  1  enqueue strobe; one word per cycle while high.
REQ-011 SHALL have port ready  output  1  FIFO not full; the word is accepted when send_trigger and ready are both high at an edge.
REQ-012 SHALL have port signal  output  1  serial TX line; idles high.
REQ-013 SHALL have port busy  output  1  high while a frame is on the line (any state except IDLE).
REQ-014 SHALL have port fifo_count  output  $clog2(fifoDepth)+1  number of words queued, excluding the frame in flight.

Function
REQ-015 SHALL derive clkPerBit = floor(clkFreq/baudRate), giving 868 at the default values.
REQ-016 SHALL hold each line bit for exactly clkPerBit cycles, timed by a counter that restarts at every bit boundary.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-018 SHALL, in IDLE with fifo_count>0, pop the head word at the edge and enter START; signal goes low from that edge.
REQ-019 SHALL, after START, send dataBits bits LSB first in DATA.
REQ-020 SHALL, after DATA, enter PARITY when parityMode!=0; otherwise it SHALL enter STOP directly.
REQ-021 SHALL drive PARITY as the XOR of the payload bits (even mode) or its inverse (odd mode), computed from the latched word.
REQ-022 SHALL drive STOP high for stopBits*clkPerBit cycles, then return to IDLE.
REQ-023 SHALL, when the FIFO is non-empty at the end of STOP, pop the next word at that same edge and go directly to START, so consecutive frames have no idle gap.
REQ-024 SHALL make the total frame length (1+dataBits+(parityMode!=0)+stopBits)*clkPerBit cycles.
REQ-025 SHALL latch the popped word into a shift register; later changes to data or the FIFO SHALL NOT affect the frame in flight.
REQ-026 SHALL ignore send_trigger while ready=0 (FIFO full): the word is dropped and fifo_count is unchanged.
REQ-027 SHALL, on a push and pop at the same edge, leave fifo_count unchanged and keep word order.
REQ-028 SHALL derive ready combinationally from the registered count (ready = fifo_count<fifoDepth), so there is no same-cycle pop-through.
REQ-029 SHALL wrap the FIFO read and write pointers modulo fifoDepth, and SHALL NOT lose or duplicate a word at wrap-around.
REQ-030 SHALL register signal so the line is glitch-free.

Reset
REQ-031 SHALL, while rst=1, force signal=1, busy=0, fifo_count=0, ready=1, FSM=IDLE, and clear the bit counter and FIFO pointers.
REQ-032 SHALL, when rst asserts mid-frame, drive signal high immediately (asynchronously) and discard the frame in flight and all queued words.
REQ-033 SHALL, after rst deasserts, start no frame until a new word is pushed.

Verification
REQ-034 SHALL be verified by the scenario: defaults, push 0xA5 once -> signal low 868 cycles, then bits 1,0,1,0,0,1,0,1, then high; busy high for 8680 cycles.
REQ-035 SHALL be verified by the scenario: parityMode=1, stopBits=2, push 0x07 -> parity bit 1, two stop bits, frame 10416 cycles; parityMode=2 -> parity bit 0.
REQ-036 SHALL be verified by the scenario: push 0x00..0x0F back-to-back (fifoDepth=16), checking each word with a uart_recv instance -> all 16 received in order, no idle gap between frames, ready never drops below full+1 misuse.
REQ-037 SHALL be verified by the scenario: fill to 16 while the first frame is in flight and push 0xEE with ready=0 -> 0xEE never transmitted; fifo_count holds at 16.
REQ-038 SHALL be verified by the scenario: push 300 words, keeping count between 1 and 15, with simultaneous push/pop -> pointers wrap and every byte is received exactly once, in order.
REQ-039 SHALL be verified by the scenario: assert rst during DATA bit 3 with 4 words queued -> signal=1 the same cycle, fifo_count=0, busy=0, and no frame after release.
